// File: rtl/fu_join_pkg.sv
// Shared definitions for the two-operand join buffer: mode encoding and defaults.
package fu_join_pkg;

  localparam int FU_JOIN_CFG_W     = 2;
  localparam int FU_JOIN_DEPTH_DEF = 2;

  typedef enum logic [FU_JOIN_CFG_W-1:0] {
    MODE_JOIN    = 2'd0,
    MODE_PASS0   = 2'd1,
    MODE_PASS1   = 2'd2,
    MODE_STICKY1 = 2'd3
  } fu_join_mode_e;

endpackage

// File: rtl/fu_join_fifo.sv
// Small operand FIFO; DEPTH must be a power of two (pointers wrap naturally).
module fu_join_fifo #(
  parameter int size  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [size-1:0] din,
  input  logic            pop,
  output logic [size-1:0] head,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [size-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fu_join2_2_1.sv
// Operand join buffer in front of a two-input ALU cell: two operand FIFOs, mode-dependent
// fire logic, sticky in1 register and a registered output stage. Optional FU_JOIN_STATS_EN adds fire_cnt.
module fu_join2_2_1
  import fu_join_pkg::*;
#(
  parameter int size  = 32,
  parameter int DEPTH = FU_JOIN_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FU_JOIN_CFG_W-1:0] config_sig,
  input  logic [size-1:0]          in0,
  input  logic                     in0_valid,
  output logic                     in0_ready,
  input  logic [size-1:0]          in1,
  input  logic                     in1_valid,
  output logic                     in1_ready,
  output logic [size-1:0]          out0,
  output logic [size-1:0]          out1,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef FU_JOIN_STATS_EN
  ,
  output logic [15:0]              fire_cnt
`endif
);

  fu_join_mode_e          mode;
  logic [FU_JOIN_CFG_W-1:0] cfg_q;
  logic                   cfg_chg;
  logic [size-1:0]        head0;
  logic [size-1:0]        head1;
  logic                   empty0;
  logic                   empty1;
  logic                   full0;
  logic                   full1;
  logic                   pop0;
  logic                   pop1;
  logic                   fire;
  logic                   sticky_load;
  logic                   sticky_vld;
  logic [size-1:0]        sticky_q;
  logic                   slot_free;
  logic [size-1:0]        nxt0;
  logic [size-1:0]        nxt1;

  assign mode      = fu_join_mode_e'(config_sig);
  assign cfg_chg   = (config_sig != cfg_q);
  assign in0_ready = !full0;
  assign in1_ready = !full1;
  assign slot_free = !out_valid || out_ready;

  fu_join_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(in0_valid && in0_ready), .din(in0),
    .pop(pop0), .head(head0), .empty(empty0), .full(full0)
  );

  fu_join_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(in1_valid && in1_ready), .din(in1),
    .pop(pop1), .head(head1), .empty(empty1), .full(full1)
  );

  // Sticky capture is held off while a mode change is pending so a token is never
  // loaded into a register that is being cleared in the same cycle.
  always_comb begin
    fire        = 1'b0;
    pop0        = 1'b0;
    pop1        = 1'b0;
    sticky_load = 1'b0;
    nxt0        = '0;
    nxt1        = '0;
    case (mode)
      MODE_JOIN: begin
        if (!empty0 && !empty1 && slot_free) begin
          fire = 1'b1; pop0 = 1'b1; pop1 = 1'b1;
          nxt0 = head0; nxt1 = head1;
        end
      end
      MODE_PASS0: begin
        if (!empty0 && slot_free) begin
          fire = 1'b1; pop0 = 1'b1; nxt0 = head0;
        end
      end
      MODE_PASS1: begin
        if (!empty1 && slot_free) begin
          fire = 1'b1; pop1 = 1'b1; nxt1 = head1;
        end
      end
      default: begin
        if (!sticky_vld) begin
          if (!empty1 && !cfg_chg) begin
            sticky_load = 1'b1; pop1 = 1'b1;
          end
        end else if (!empty0 && slot_free) begin
          fire = 1'b1; pop0 = 1'b1;
          nxt0 = head0; nxt1 = sticky_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      sticky_vld <= 1'b0;
      out_valid  <= 1'b0;
      out0       <= '0;
      out1       <= '0;
    end else begin
      cfg_q <= config_sig;
      if (cfg_chg)          sticky_vld <= 1'b0;
      else if (sticky_load) sticky_vld <= 1'b1;
      if (fire) begin
        out_valid <= 1'b1;
        out0      <= nxt0;
        out1      <= nxt1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sticky_load) sticky_q <= head1;
  end

`ifdef FU_JOIN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          fire_cnt <= '0;
    else if (fire && fire_cnt != 16'hFFFF) fire_cnt <= fire_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fu_join2_2_1.sv
// Scoreboard bench for fu_join2_2_1: token-level reference model feeds an expected-pair queue.
module tb_fu_join2_2_1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  config_sig = 2'd0;
  logic [31:0] in0 = '0, in1 = '0;
  logic        in0_valid = 1'b0, in1_valid = 1'b0;
  logic        in0_ready, in1_ready;
  logic [31:0] out0, out1;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef FU_JOIN_STATS_EN
  logic [15:0] fire_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_pairs = 0;

  fu_join2_2_1 #(.size(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .config_sig(config_sig),
    .in0(in0), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1(in1), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out0(out0), .out1(out1), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FU_JOIN_STATS_EN
    , .fire_cnt(fire_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: accepted tokens per input, resolved into pairs by mode rules.
  logic [31:0] q0[$], q1[$];
  logic [63:0] exp_q[$];
  logic [1:0]  m_cfg = 2'd0;
  logic        sticky_have = 1'b0;
  logic [31:0] sticky_val = '0;

  task automatic resolve();
    case (m_cfg)
      2'd0: while (q0.size() > 0 && q1.size() > 0) exp_q.push_back({q0.pop_front(), q1.pop_front()});
      2'd1: while (q0.size() > 0) exp_q.push_back({q0.pop_front(), 32'd0});
      2'd2: while (q1.size() > 0) exp_q.push_back({32'd0, q1.pop_front()});
      default: begin
        if (!sticky_have && q1.size() > 0) begin
          sticky_val  = q1.pop_front();
          sticky_have = 1'b1;
        end
        if (sticky_have) while (q0.size() > 0) exp_q.push_back({q0.pop_front(), sticky_val});
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pair: got %0h expected none", {out0, out1});
        end else begin
          check("pair", {out0, out1}, exp_q.pop_front());
          n_pairs++;
        end
      end
      if (in0_valid && in0_ready) q0.push_back(in0);
      if (in1_valid && in1_ready) q1.push_back(in1);
      resolve();
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic set_mode(input logic [1:0] m);
    config_sig = m;
    if (m != m_cfg) sticky_have = 1'b0;
    m_cfg = m;
    resolve();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete();
    sticky_have = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input int n);
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic send0(input logic [31:0] d);
    in0 = d; in0_valid = 1'b1; step(); in0_valid = 1'b0;
  endtask

  task automatic send1(input logic [31:0] d);
    in1 = d; in1_valid = 1'b1; step(); in1_valid = 1'b0;
  endtask

  task automatic fill_backpressured(output int a0, output int a1);
    a0 = 0; a1 = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in0 = 32'd100 + 32'(a0); in0_valid = (a0 < 4);
      in1 = 32'd200 + 32'(a1); in1_valid = (a1 < 4);
      #1;
      if (in0_valid && in0_ready) a0++;
      if (in1_valid && in1_ready) a1++;
      step();
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  initial begin
    int a0, a1;
    logic [63:0] held;
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {out0, out1}, 64'd0);
    check("rst_readies", {62'd0, in0_ready, in1_ready}, 64'd3);
    do_reset();
    check("post_rst_readies", {62'd0, in0_ready, in1_ready}, 64'd3);
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
`ifdef FU_JOIN_STATS_EN
    check("rst_fire_cnt", {48'd0, fire_cnt}, 64'd0);
`endif

    // JOIN latency: in0 at cycle 0, in1 at cycle 3, valid only in cycle 5
    set_mode(2'd0); out_ready = 1'b1;
    send0(32'd5);
    step(); step();
    send1(32'd7);
    check("join_c4_valid", {63'd0, out_valid}, 64'd0);
    step();
    check("join_c5_valid", {63'd0, out_valid}, 64'd1);
    check("join_c5_data", {out0, out1}, {32'd5, 32'd7});
    step();
    check("join_c6_valid", {63'd0, out_valid}, 64'd0);

    // JOIN backpressure
    fill_backpressured(a0, a1);
    check("bp_acc0", 64'(a0), 64'd3);
    check("bp_acc1", 64'(a1), 64'd3);
    check("bp_readies", {62'd0, in0_ready, in1_ready}, 64'd0);
    held = {out0, out1};
    check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    repeat (3) step();
    check("bp_hold_data", {out0, out1}, held);
    check("bp_first_pair", held, {32'd100, 32'd200});
    drain(6);
    check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // PASS0 stream with throughput check
    set_mode(2'd1); out_ready = 1'b1;
    in0 = 32'd1; in0_valid = 1'b1; step();
    in0 = 32'd2; step();
    in0 = 32'd3; check("pass0_c2_valid", {63'd0, out_valid}, 64'd1); step();
    in0_valid = 1'b0; check("pass0_c3_valid", {63'd0, out_valid}, 64'd1);
    check("pass0_c3_data", {out0, out1}, {32'd2, 32'd0});
    step();
    check("pass0_c4_valid", {63'd0, out_valid}, 64'd1);
    send1(32'd9);
    check("pass0_in1_ready", {63'd0, in1_ready}, 64'd1);
    drain(5);
    check("pass0_sb_empty", 64'(exp_q.size()), 64'd0);
    do_reset();

    // STICKY1 then back to JOIN
    set_mode(2'd3); out_ready = 1'b1;
    step();
    send1(32'd4);
    step(); step();
    send0(32'd10); send0(32'd11); send0(32'd12);
    send1(32'd8);
    drain(6);
    check("sticky_last", {out0, out1}, {32'd12, 32'd4});
    set_mode(2'd0);
    step();
    send0(32'd13);
    drain(5);
    check("join_after_sticky", {out0, out1}, {32'd13, 32'd8});
    check("sticky_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-operation with both FIFOs full and a pair held
    fill_backpressured(a0, a1);
    check("mid_full_valid", {63'd0, out_valid}, 64'd1);
    check("mid_full_readies", {62'd0, in0_ready, in1_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_data", {out0, out1}, 64'd0);
    check("mid_rst_readies", {62'd0, in0_ready, in1_ready}, 64'd3);
    q0.delete(); q1.delete(); exp_q.delete(); sticky_have = 1'b0;
    m_cfg = 2'd0; config_sig = 2'd0;
    #2; rst_n = 1'b1;
    drain(5);
    check("post_mid_rst_valid", {63'd0, out_valid}, 64'd0);

    // Randomized phases across all modes
    for (int p = 0; p < 16; p++) begin
      set_mode(2'($urandom_range(0, 3)));
      for (int c = 0; c < 60; c++) begin
        in0 = $urandom(); in0_valid = ($urandom_range(0, 3) != 0);
        in1 = $urandom(); in1_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        step();
      end
      drain(8);
    end
    check("rand_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef FU_JOIN_STATS_EN
    do_reset();
    set_mode(2'd1); out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in0 = $urandom(); in0_valid = 1'b1; step();
    end
    drain(5);
    check("fire_cnt_100", {48'd0, fire_cnt}, 64'd100);
    for (int i = 0; i < 70000; i++) begin
      in0 = $urandom(); in0_valid = 1'b1; step();
    end
    drain(5);
    check("fire_cnt_sat", {48'd0, fire_cnt}, 64'hFFFF);
`endif

    for (int w = 0; w < 50 && exp_q.size() != 0; w++) step();
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
